// File: rtl/demux_rr_dispatcher_pkg.sv
// Shared types and constants for the 1-to-4 demux dispatcher.
package demux_pkg;

  localparam int unsigned NUM_OUT = 4;
  localparam int unsigned SEL_W   = 2;

  localparam logic MODE_RR  = 1'b0;
  localparam logic MODE_DIR = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

endpackage

// File: rtl/demux_rr_dispatcher_rr_pick4.sv
// Rotating-priority picker: first free channel starting at ptr, wrapping mod 4.
module rr_pick4
  import demux_pkg::*;
(
  input  logic [NUM_OUT-1:0] free,
  input  logic [SEL_W-1:0]   ptr,
  output logic [SEL_W-1:0]   grant,
  output logic               any_free
);

  logic [SEL_W-1:0] idx;

  // Walk from the farthest candidate back to ptr so the nearest free one wins.
  always_comb begin
    idx   = '0;
    grant = ptr;
    for (int k = int'(NUM_OUT) - 1; k >= 0; k--) begin
      idx = ptr + SEL_W'(k);
      if (free[idx]) grant = idx;
    end
  end

  assign any_free = |free;

endmodule

// File: rtl/demux_rr_dispatcher.sv
// 1-to-4 valid/ready dispatcher with one-entry holding register per channel,
// round-robin or directed channel choice, and enable/flush sequencing.
module demux_rr_dispatcher
  import demux_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      flush_req,
  input  logic                      mode,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_data,
  input  logic [SEL_W-1:0]          in_dest,
  output logic [NUM_OUT-1:0]        out_valid,
  input  logic [NUM_OUT-1:0]        out_ready,
  output logic [NUM_OUT*DATA_W-1:0] out_data,
  output logic                      busy,
  output logic                      flush_done
);

  state_e                    state_q, state_d;
  logic [SEL_W-1:0]          ptr_q, ptr_d;
  logic [NUM_OUT-1:0]        out_valid_q, out_valid_d;
  logic [NUM_OUT*DATA_W-1:0] out_data_q, out_data_d;
  logic                      flush_done_q, flush_done_d;

  logic [NUM_OUT-1:0]        free;
  logic [SEL_W-1:0]          grant;
  logic                      any_free;
  logic [SEL_W-1:0]          target;
  logic                      accept;

  // A channel can take a new beat if empty or draining this cycle.
  assign free = ~out_valid_q | out_ready;

  rr_pick4 u_pick (
    .free     (free),
    .ptr      (ptr_q),
    .grant    (grant),
    .any_free (any_free)
  );

  always_comb begin
    target   = (mode == MODE_DIR) ? in_dest : grant;
    in_ready = 1'b0;
    if (state_q == RUN) begin
      in_ready = (mode == MODE_DIR) ? free[in_dest] : any_free;
    end
  end

  assign accept = in_valid & in_ready;

  always_comb begin
    state_d      = state_q;
    flush_done_d = 1'b0;
    case (state_q)
      IDLE:  if (enable && !flush_req) state_d = RUN;
      RUN:   if (flush_req || !enable) state_d = FLUSH;
      FLUSH: begin
        if (out_valid_q == '0) begin
          state_d      = IDLE;
          flush_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Holding registers: a load wins over a drain on the same channel.
  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    for (int unsigned i = 0; i < NUM_OUT; i++) begin
      if (accept && (target == SEL_W'(i))) begin
        out_valid_d[i]                = 1'b1;
        out_data_d[i*DATA_W +: DATA_W] = in_data;
      end else if (out_ready[i]) begin
        out_valid_d[i] = 1'b0;
      end
    end
    if (accept && (mode == MODE_RR)) ptr_d = grant + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      out_valid_q  <= '0;
      out_data_q   <= '0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      flush_done_q <= flush_done_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign flush_done = flush_done_q;
  assign busy       = (state_q != IDLE) | (|out_valid_q);

endmodule

// File: tb/tb_demux_rr_dispatcher.sv
// Directed table-driven bench for demux_rr_dispatcher.
module tb_demux_rr_dispatcher;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        flush_req = 1'b0;
  logic        mode = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic [1:0]  in_dest = '0;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready = '0;
  logic [31:0] out_data;
  logic        busy;
  logic        flush_done;

  int checks = 0;
  int errors = 0;

  demux_rr_dispatcher #(.DATA_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .flush_req  (flush_req),
    .mode       (mode),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_dest    (in_dest),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .flush_done (flush_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en, fl, md, iv;
    logic [7:0]  din;
    logic [1:0]  dst;
    logic [3:0]  ordy;
    logic        ir;
    logic [3:0]  ov;
    logic [31:0] od;
    logic        fd, bz;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic en, logic fl, logic md, logic iv, logic [7:0] din,
                              logic [1:0] dst, logic [3:0] ordy, logic ir, logic [3:0] ov,
                              logic [31:0] od, logic fd, logic bz);
    vec_t v;
    v.en = en; v.fl = fl; v.md = md; v.iv = iv; v.din = din; v.dst = dst; v.ordy = ordy;
    v.ir = ir; v.ov = ov; v.od = od; v.fd = fd; v.bz = bz;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs at negedge, in_ready checked before the edge, registered outputs after it.
  task automatic run_vec(input int i);
    vec_t v;
    v = tbl[i];
    @(negedge clk);
    enable = v.en; flush_req = v.fl; mode = v.md; in_valid = v.iv;
    in_data = v.din; in_dest = v.dst; out_ready = v.ordy;
    #1;
    chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(v.ir));
    @(posedge clk);
    #1;
    chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(v.ov));
    chk($sformatf("v%0d out_data", i), out_data, v.od);
    chk($sformatf("v%0d flush_done", i), 32'(flush_done), 32'(v.fd));
    chk($sformatf("v%0d busy", i), 32'(busy), 32'(v.bz));
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, " out_valid"}, 32'(out_valid), 32'h0);
    chk({tag, " out_data"}, out_data, 32'h0);
    chk({tag, " in_ready"}, 32'(in_ready), 32'h0);
    chk({tag, " flush_done"}, 32'(flush_done), 32'h0);
  endtask

  initial begin
    // Round-robin, all consumers ready
    tbl.push_back(mk(1,0,0,0,8'h00,0,4'hF, 0,4'b0000,32'h00000000,0,1));
    tbl.push_back(mk(1,0,0,1,8'h10,0,4'hF, 1,4'b0001,32'h00000010,0,1));
    tbl.push_back(mk(1,0,0,1,8'h11,0,4'hF, 1,4'b0010,32'h00001110,0,1));
    tbl.push_back(mk(1,0,0,1,8'h12,0,4'hF, 1,4'b0100,32'h00121110,0,1));
    tbl.push_back(mk(1,0,0,1,8'h13,0,4'hF, 1,4'b1000,32'h13121110,0,1));
    tbl.push_back(mk(1,0,0,1,8'h14,0,4'hF, 1,4'b0001,32'h13121114,0,1));
    tbl.push_back(mk(1,0,0,1,8'h15,0,4'hF, 1,4'b0010,32'h13121514,0,1));
    tbl.push_back(mk(1,0,0,0,8'h00,0,4'hF, 1,4'b0000,32'h13121514,0,1));
    tbl.push_back(mk(1,0,0,1,8'h16,0,4'hF, 1,4'b0100,32'h13161514,0,1));
    tbl.push_back(mk(1,0,0,1,8'h17,0,4'hF, 1,4'b1000,32'h17161514,0,1));
    // Channel 1 stalled
    tbl.push_back(mk(1,0,0,1,8'hA0,0,4'hD, 1,4'b0001,32'h171615A0,0,1));
    tbl.push_back(mk(1,0,0,1,8'hB1,0,4'hD, 1,4'b0010,32'h1716B1A0,0,1));
    tbl.push_back(mk(1,0,0,1,8'hC2,0,4'hD, 1,4'b0110,32'h17C2B1A0,0,1));
    tbl.push_back(mk(1,0,0,1,8'hD3,0,4'hD, 1,4'b1010,32'hD3C2B1A0,0,1));
    tbl.push_back(mk(1,0,0,1,8'hE4,0,4'hD, 1,4'b0011,32'hD3C2B1E4,0,1));
    tbl.push_back(mk(1,0,0,1,8'hF5,0,4'hD, 1,4'b0110,32'hD3F5B1E4,0,1));
    tbl.push_back(mk(1,0,0,0,8'h00,0,4'hF, 1,4'b0000,32'hD3F5B1E4,0,1));
    // Directed to channel 2 with channel 2 stalled
    tbl.push_back(mk(1,0,1,1,8'h55,2,4'hB, 1,4'b0100,32'hD355B1E4,0,1));
    tbl.push_back(mk(1,0,1,1,8'h66,2,4'hB, 0,4'b0100,32'hD355B1E4,0,1));
    tbl.push_back(mk(1,0,1,1,8'h66,2,4'hB, 0,4'b0100,32'hD355B1E4,0,1));
    tbl.push_back(mk(1,0,1,1,8'h66,2,4'hF, 1,4'b0100,32'hD366B1E4,0,1));
    tbl.push_back(mk(1,0,0,0,8'h00,0,4'hF, 1,4'b0000,32'hD366B1E4,0,1));
    // Fill all channels, then free only channel 3
    tbl.push_back(mk(1,0,0,1,8'h20,0,4'h0, 1,4'b1000,32'h2066B1E4,0,1));
    tbl.push_back(mk(1,0,0,1,8'h21,0,4'h0, 1,4'b1001,32'h2066B121,0,1));
    tbl.push_back(mk(1,0,0,1,8'h22,0,4'h0, 1,4'b1011,32'h20662221,0,1));
    tbl.push_back(mk(1,0,0,1,8'h23,0,4'h0, 1,4'b1111,32'h20232221,0,1));
    tbl.push_back(mk(1,0,0,1,8'h24,0,4'h0, 0,4'b1111,32'h20232221,0,1));
    tbl.push_back(mk(1,0,0,1,8'h24,0,4'h8, 1,4'b1111,32'h24232221,0,1));
    tbl.push_back(mk(1,0,0,1,8'h25,0,4'hF, 1,4'b0001,32'h24232225,0,1));
    // Flush with an accept in the same cycle
    tbl.push_back(mk(1,0,0,1,8'h26,0,4'h0, 1,4'b0011,32'h24232625,0,1));
    tbl.push_back(mk(1,1,0,1,8'h27,0,4'h0, 1,4'b0111,32'h24272625,0,1));
    tbl.push_back(mk(1,0,0,1,8'h28,0,4'h0, 0,4'b0111,32'h24272625,0,1));
    tbl.push_back(mk(1,0,0,0,8'h00,0,4'hF, 0,4'b0000,32'h24272625,0,1));
    tbl.push_back(mk(1,0,0,0,8'h00,0,4'hF, 0,4'b0000,32'h24272625,1,0));
    tbl.push_back(mk(1,0,0,0,8'h00,0,4'hF, 0,4'b0000,32'h24272625,0,1));
    // Enable drop behaves like a flush
    tbl.push_back(mk(1,0,0,1,8'h30,0,4'hF, 1,4'b1000,32'h30272625,0,1));
    tbl.push_back(mk(0,0,0,0,8'h00,0,4'h0, 1,4'b1000,32'h30272625,0,1));
    tbl.push_back(mk(0,0,0,0,8'h00,0,4'hF, 0,4'b0000,32'h30272625,0,1));
    tbl.push_back(mk(0,0,0,0,8'h00,0,4'hF, 0,4'b0000,32'h30272625,1,0));
    tbl.push_back(mk(0,0,0,0,8'h00,0,4'hF, 0,4'b0000,32'h30272625,0,0));
    // Hold two beats with ptr away from 0 before an async reset
    tbl.push_back(mk(1,0,0,0,8'h00,0,4'hF, 0,4'b0000,32'h30272625,0,1));
    tbl.push_back(mk(1,0,0,1,8'h40,0,4'h0, 1,4'b0001,32'h30272640,0,1));
    tbl.push_back(mk(1,0,0,1,8'h41,0,4'h0, 1,4'b0011,32'h30274140,0,1));
    // After reset: pointer back at channel 0
    tbl.push_back(mk(1,0,0,0,8'h00,0,4'h0, 0,4'b0000,32'h00000000,0,1));
    tbl.push_back(mk(1,0,0,1,8'h50,0,4'h0, 1,4'b0001,32'h00000050,0,1));

    #2 rst = 1'b1;
    #20;
    check_reset_state("reset");
    chk("reset busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i <= 42; i++) run_vec(i);

    // Asynchronous reset between clock edges with beats held
    #2 rst = 1'b1;
    #1;
    check_reset_state("midreset");
    enable = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    for (int i = 43; i < tbl.size(); i++) run_vec(i);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, required completion before 100000");
    $fatal(1, "timeout");
  end

endmodule
